// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side fields in, write-back producers in, EX-side fields out.
// Latency: none, this is wiring only.
// Backpressure: the stage's stall output is carried back to the fetch side here.
interface id_ex_stage_if;
  // Decode-side inputs
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_write_reg;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_shamt;
  logic [31:0] id_read_data1;
  logic [31:0] id_read_data2;
  logic [31:0] id_imm;

  // Results from later stages
  logic        exmem_reg_write;
  logic [4:0]  exmem_write_reg;
  logic [31:0] exmem_alu_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_write_reg;
  logic [31:0] memwb_write_data;

  // EX-side outputs
  logic        stall;
  logic        ex_valid;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [31:0] ex_store_data;
  logic [15:0] bubble_count;

  // Driver side (decode logic / testbench)
  modport master (
    output flush, id_valid, id_rs, id_rt, id_write_reg, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op,
           id_shamt, id_read_data1, id_read_data2, id_imm,
           exmem_reg_write, exmem_write_reg, exmem_alu_result,
           memwb_reg_write, memwb_write_reg, memwb_write_data,
    input  stall, ex_valid, ALUOperation, A, B, shamt, ex_write_reg,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_store_data, bubble_count
  );

  // Pipeline register side
  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_write_reg, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op,
           id_shamt, id_read_data1, id_read_data2, id_imm,
           exmem_reg_write, exmem_write_reg, exmem_alu_result,
           memwb_reg_write, memwb_write_reg, memwb_write_data,
    output stall, ex_valid, ALUOperation, A, B, shamt, ex_write_reg,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_store_data, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall, bubble insertion and operand forwarding (FORWARDING_EN).
// Latency: 1 cycle for captured fields; A/B/ex_store_data are combinational off the register.
// Backpressure: stall holds PC and IF/ID while a bubble enters EX; flush overrides stall.
module id_ex_stage (
  input logic        clk,
  input logic        reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } pipe_t;

  pipe_t       pipe_q, pipe_d;
  logic [15:0] bubble_count_q, bubble_count_d;
  logic        hazard;
  logic        stall_w;
  logic        bubble;
  logic [31:0] op_a;
  logic [31:0] op_rt;

`ifdef FORWARDING_EN
  // Newest producer wins; $0 is hardwired and never forwarded.
  function automatic logic [31:0] fwd_pick(
    input logic [4:0]  src,
    input logic [31:0] regval,
    input logic        em_en,
    input logic [4:0]  em_dst,
    input logic [31:0] em_val,
    input logic        mw_en,
    input logic [4:0]  mw_dst,
    input logic [31:0] mw_val
  );
    if (em_en && em_dst != 5'd0 && em_dst == src)
      return em_val;
    if (mw_en && mw_dst != 5'd0 && mw_dst == src)
      return mw_val;
    return regval;
  endfunction
`else
  // A nonzero source matches a pending write to the same register.
  function automatic logic src_hit(
    input logic [4:0] src,
    input logic       en,
    input logic [4:0] dst
  );
    return en && src != 5'd0 && src == dst;
  endfunction
`endif

  // Hazard detection: load-use only with forwarding, any in-flight RAW without it.
  always_comb begin
    hazard = 1'b0;
`ifdef FORWARDING_EN
    if (bus.id_valid && pipe_q.valid && pipe_q.mem_read && pipe_q.wr != 5'd0 &&
        (pipe_q.wr == bus.id_rs || pipe_q.wr == bus.id_rt))
      hazard = 1'b1;
`else
    if (bus.id_valid &&
        (src_hit(bus.id_rs, pipe_q.valid && pipe_q.reg_write, pipe_q.wr) ||
         src_hit(bus.id_rt, pipe_q.valid && pipe_q.reg_write, pipe_q.wr) ||
         src_hit(bus.id_rs, bus.exmem_reg_write, bus.exmem_write_reg) ||
         src_hit(bus.id_rt, bus.exmem_reg_write, bus.exmem_write_reg) ||
         src_hit(bus.id_rs, bus.memwb_reg_write, bus.memwb_write_reg) ||
         src_hit(bus.id_rt, bus.memwb_reg_write, bus.memwb_write_reg)))
      hazard = 1'b1;
`endif
  end

  // Stall is silenced in reset and by flush, which squashes the ID instruction anyway.
  assign stall_w = reset && !bus.flush && hazard;
  assign bubble  = bus.flush || stall_w;

  // Next-state: capture decode fields, or load an all-zero bubble.
  always_comb begin
    pipe_d         = '0;
    bubble_count_d = bubble_count_q;
    if (bubble) begin
      if (bubble_count_q != 16'hFFFF)
        bubble_count_d = bubble_count_q + 16'd1;
    end else begin
      pipe_d.valid      = bus.id_valid;
      pipe_d.rs         = bus.id_rs;
      pipe_d.rt         = bus.id_rt;
      pipe_d.wr         = bus.id_write_reg;
      pipe_d.reg_write  = bus.id_reg_write;
      pipe_d.mem_read   = bus.id_mem_read;
      pipe_d.mem_write  = bus.id_mem_write;
      pipe_d.mem_to_reg = bus.id_mem_to_reg;
      pipe_d.alu_src    = bus.id_alu_src;
      pipe_d.alu_op     = bus.id_alu_op;
      pipe_d.shamt      = bus.id_shamt;
      pipe_d.rd1        = bus.id_read_data1;
      pipe_d.rd2        = bus.id_read_data2;
      pipe_d.imm        = bus.id_imm;
    end
  end

  // Pipeline register and bubble counter; reset overrides flush and stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_q         <= '0;
      bubble_count_q <= '0;
    end else begin
      pipe_q         <= pipe_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  // Operand selection off the registered instruction.
  always_comb begin
`ifdef FORWARDING_EN
    op_a  = fwd_pick(pipe_q.rs, pipe_q.rd1,
                     bus.exmem_reg_write, bus.exmem_write_reg, bus.exmem_alu_result,
                     bus.memwb_reg_write, bus.memwb_write_reg, bus.memwb_write_data);
    op_rt = fwd_pick(pipe_q.rt, pipe_q.rd2,
                     bus.exmem_reg_write, bus.exmem_write_reg, bus.exmem_alu_result,
                     bus.memwb_reg_write, bus.memwb_write_reg, bus.memwb_write_data);
`else
    op_a  = pipe_q.rd1;
    op_rt = pipe_q.rd2;
`endif
  end

`ifndef FORWARDING_EN
  // Without forwarding these only feed nothing; fold them so the intent is explicit.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{bus.exmem_alu_result, bus.memwb_write_data, pipe_q.rs, pipe_q.rt};
`endif

  assign bus.stall         = stall_w;
  assign bus.ex_valid      = pipe_q.valid;
  assign bus.ALUOperation  = pipe_q.alu_op;
  assign bus.A             = op_a;
  assign bus.B             = pipe_q.alu_src ? pipe_q.imm : op_rt;
  assign bus.shamt         = pipe_q.shamt;
  assign bus.ex_write_reg  = pipe_q.wr;
  assign bus.ex_reg_write  = pipe_q.reg_write;
  assign bus.ex_mem_read   = pipe_q.mem_read;
  assign bus.ex_mem_write  = pipe_q.mem_write;
  assign bus.ex_mem_to_reg = pipe_q.mem_to_reg;
  assign bus.ex_store_data = op_rt;
  assign bus.bubble_count  = bubble_count_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low: clk  in  1  rising-edge clock; reset  in  1  synchronous active-low reset.
REQ-002 The block SHALL have these inputs: flush 1 squash ID instruction; id_valid 1; id_rs/id_rt/id_write_reg 5 each; id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src 1 each; id_alu_op 4; id_shamt 5; id_read_data1, id_read_data2, id_imm 32 each.
REQ-003 The block SHALL have these write-back inputs: exmem_reg_write 1, exmem_write_reg 5, exmem_alu_result 32, memwb_reg_write 1, memwb_write_reg 5, memwb_write_data 32.
REQ-004 The block SHALL have these outputs: stall 1 hold PC and IF/ID; ex_valid 1; ALUOperation 4; A, B 32 each; shamt 5; ex_write_reg 5; ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg 1 each; ex_store_data 32; bubble_count 16.

Function
REQ-005 The block SHALL capture all id_* fields on every rising clk edge, except when a bubble is inserted.
- Capture latency: 1 cycle.
REQ-006 A bubble SHALL load ex_valid=0, all control bits=0, ALUOperation=4'b0000, write_reg=0 and operands=0.
REQ-007 A bubble SHALL be inserted when flush=1 or stall=1.
REQ-008 With the macro defined, stall SHALL be 1 on a load-use hazard: id_valid & ex_valid & ex_mem_read & ex_write_reg!=0 & (ex_write_reg==id_rs | ex_write_reg==id_rt).
REQ-009 stall SHALL be forced to 0 whenever flush=1; flush has priority.
REQ-010 Forwarding for A, with the macro defined:
- If exmem_reg_write, exmem_write_reg!=0 and it equals the registered rs: select exmem_alu_result.
- Else, under the same test on memwb_*: select memwb_write_data.
- Else: select registered read_data1.
- EX/MEM has priority over MEM/WB.
REQ-011 The forwarded rt value SHALL use the same selection as REQ-010 and SHALL drive ex_store_data.
REQ-012 B SHALL equal registered imm when registered alu_src=1, else the forwarded rt value.
REQ-013 A, B and ex_store_data SHALL be combinational from registered state plus the exmem/memwb inputs; all other outputs SHALL be direct register outputs.
REQ-014 Register 0 SHALL never match for forwarding or hazard purposes.
REQ-015 bubble_count SHALL increment by 1 on each clock edge where a bubble is loaded and reset is high, saturating at 16'hFFFF.

Reset
REQ-016 When reset=0 at a rising edge, all registered outputs and bubble_count SHALL become 0, including ex_valid.
REQ-017 During reset, stall SHALL evaluate to 0.
REQ-018 Reset SHALL take priority over flush and stall, including mid-stall.
REQ-019 The first edge with reset=1 SHALL capture id_* normally.

Configuration
REQ-020 Macro FORWARDING_EN defined: REQ-008 and REQ-010/011 apply.
REQ-021 Macro FORWARDING_EN undefined:
- A SHALL equal registered read_data1, and the rt value SHALL equal registered read_data2.
- stall SHALL be 1 on any RAW hazard: id_valid and a nonzero id_rs or id_rt equals ex_write_reg (ex_valid & ex_reg_write), exmem_write_reg (exmem_reg_write) or memwb_write_reg (memwb_reg_write).
- The flush priority of REQ-009 still applies.

Verification
REQ-022 Forwarding EX/MEM over MEM/WB: registered rs=5, exmem(1,5,32'h11), memwb(1,5,32'h22) -> A=32'h11; drop exmem_reg_write -> A=32'h22.
REQ-023 Load-use stall:
- Stimulus: EX holds lw to $8; ID presents rs=8 with id_valid=1.
- Required: stall=1 for one cycle; next cycle ex_valid=0 and bubble_count=1; the following cycle the held instruction is captured and stall=0.
REQ-024 Flush beats stall: same hazard as REQ-023 with flush=1 -> stall=0, a bubble loads, bubble_count increments.
REQ-025 $0 immunity: exmem_write_reg=0 with exmem_reg_write=1 and registered rs=0, read_data1=0 -> A=0 and no stall.
REQ-026 Reset mid-stall: reset=0 during a stall cycle -> next edge all outputs 0, stall=0, bubble_count=0.
REQ-027 No-forwarding build: FORWARDING_EN undefined, memwb_write_reg=3 with memwb_reg_write=1, ID rt=3 -> stall=1 until memwb_reg_write drops.
